// File: rtl/burst_line_adaptor_pkg.sv
// Shared constants and state encoding for the L2 line to memory burst adaptor.
// Every width the adaptor uses is derived from the line and beat widths here.
package burst_adaptor_pkg;

    localparam int LINE_W = 256;
    localparam int BEAT_W = 64;
    localparam int ADDR_W = 32;

    // The line must hold a whole number of memory beats.
    localparam int BEATS  = LINE_W / BEAT_W;
    localparam int OFFS   = $clog2(LINE_W / 8);
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } state_t;

endpackage

// File: rtl/burst_line_adaptor_if.sv
// Bundle of the L2-controller line signals and the physical-memory burst signals.
// The master side is the environment (controller plus memory); the slave side is the adaptor.
interface burst_line_adaptor_if;
    import burst_adaptor_pkg::*;

    logic [LINE_W-1:0] line_i;
    logic [LINE_W-1:0] line_o;
    logic [ADDR_W-1:0] address_i;
    logic              read_i;
    logic              write_i;
    logic              resp_o;
    logic [BEAT_W-1:0] burst_i;
    logic [BEAT_W-1:0] burst_o;
    logic [ADDR_W-1:0] address_o;
    logic              read_o;
    logic              write_o;
    logic              resp_i;

    modport master (
        output line_i, address_i, read_i, write_i, burst_i, resp_i,
        input  line_o, resp_o, burst_o, address_o, read_o, write_o
    );

    modport slave (
        input  line_i, address_i, read_i, write_i, burst_i, resp_i,
        output line_o, resp_o, burst_o, address_o, read_o, write_o
    );

endinterface

// File: rtl/burst_line_adaptor.sv
// Turns one full-line read or write from the L2 controller into a BEATS-long memory
// burst, then returns a single-cycle line response once the last beat is acknowledged.
module burst_line_adaptor
    import burst_adaptor_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    burst_line_adaptor_if.slave  bus
);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [LINE_W-1:0] buffer;
    logic [ADDR_W-1:0] addr_reg;
    logic              read_q;
    logic              write_q;
    logic              resp_q;

    // Request strobes are registered alongside the state so they change on the same edge;
    // the counter wraps to zero on the last beat and IDLE clears it again for the next request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            buffer   <= '0;
            addr_reg <= '0;
            read_q   <= 1'b0;
            write_q  <= 1'b0;
            resp_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    resp_q <= 1'b0;
                    if (bus.write_i) begin
                        buffer   <= bus.line_i;
                        addr_reg <= {bus.address_i[ADDR_W-1:OFFS], {OFFS{1'b0}}};
                        cnt      <= '0;
                        write_q  <= 1'b1;
                        state    <= WRITE;
                    end else if (bus.read_i) begin
                        addr_reg <= {bus.address_i[ADDR_W-1:OFFS], {OFFS{1'b0}}};
                        cnt      <= '0;
                        read_q   <= 1'b1;
                        state    <= READ;
                    end
                end
                READ: begin
                    if (bus.resp_i) begin
                        buffer[cnt*BEAT_W +: BEAT_W] <= bus.burst_i;
                        cnt <= cnt + ONE;
                        if (cnt == LAST_BEAT) begin
                            read_q <= 1'b0;
                            resp_q <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                WRITE: begin
                    if (bus.resp_i) begin
                        cnt <= cnt + ONE;
                        if (cnt == LAST_BEAT) begin
                            write_q <= 1'b0;
                            resp_q  <= 1'b1;
                            state   <= DONE;
                        end
                    end
                end
                DONE: begin
                    resp_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    read_q  <= 1'b0;
                    write_q <= 1'b0;
                    resp_q  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    // The outgoing write beat follows the counter directly, so a stalled beat stays on the bus.
    assign bus.burst_o   = buffer[cnt*BEAT_W +: BEAT_W];
    assign bus.line_o    = buffer;
    assign bus.address_o = addr_reg;
    assign bus.read_o    = read_q;
    assign bus.write_o   = write_q;
    assign bus.resp_o    = resp_q;

endmodule

// File: doc/burst_line_adaptor.md
Name: burst_line_adaptor

Overview:
- Memory-side responder for the L2 cache controller's line interface (pmem_read/pmem_write/pmem_resp, 256-bit lines).
- Accepts one full-line read or write request from the L2 controller.
- Converts it into a BEATS-long burst on the 64-bit physical-memory bus.
- Returns a single-cycle line response once the burst completes.

Parameters:
- LINE_W, 256, cache line width in bits.
- BEAT_W, 64, memory bus width per beat. LINE_W must be an integer multiple of BEAT_W.
- ADDR_W, 32, byte address width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- line_i  in  LINE_W  write-back line from the L2 controller.
- line_o  out  LINE_W  assembled read line to the L2 controller.
- address_i  in  ADDR_W  request byte address from the L2 controller.
- read_i  in  1  line read request; held high until resp_o.
- write_i  in  1  line write request; held high until resp_o.
- resp_o  out  1  one-cycle completion pulse to the L2 controller.
- burst_i  in  BEAT_W  read beat from memory; valid when resp_i is high.
- burst_o  out  BEAT_W  write beat to memory.
- address_o  out  ADDR_W  line-aligned burst address to memory.
- read_o  out  1  burst read request to memory.
- write_o  out  1  burst write request to memory.
- resp_i  in  1  per-beat acknowledge from memory.

Behaviour:
- Constants:
  - BEATS = LINE_W/BEAT_W (4 at defaults).
  - OFFS = log2(LINE_W/8) (5 at defaults).
  - Beat counter is log2(BEATS) bits wide.
- Reset: state=IDLE, beat counter=0, line buffer=0, address register=0. Every output is 0: resp_o, read_o, write_o, address_o, burst_o, line_o.
- Reset mid-burst: read_o/write_o drop the cycle after rst is sampled. The partial line is discarded and no resp_o is issued.
- State IDLE:
  - write_i=1: latch line_i into the buffer and {address_i[ADDR_W-1:OFFS], OFFS'b0} into the address register. Clear the counter and go to WRITE.
  - read_i=1 and write_i=0: latch the address the same way, clear the counter and go to READ.
  - read_i=1 and write_i=1 in the same cycle: write wins.
- State READ:
  - read_o=1; address_o=address register.
  - On each cycle with resp_i=1: store burst_i into buffer[cnt*BEAT_W +: BEAT_W] and increment cnt. Beat 0 fills bits BEAT_W-1:0.
  - resp_i need not be consecutive; cycles with resp_i=0 only stall.
  - When resp_i=1 and cnt=BEATS-1, go to DONE.
- State WRITE:
  - write_o=1; address_o=address register; burst_o=buffer[cnt*BEAT_W +: BEAT_W] (combinational from cnt).
  - Each resp_i=1 accepts the current beat and increments cnt.
  - The last beat goes to DONE.
- State DONE:
  - resp_o=1 for exactly one cycle; line_o=buffer (valid this cycle).
  - read_o=0 and write_o=0. Go to IDLE.
- Latency:
  - resp_o is high in the cycle after the final resp_i.
  - Minimum request-to-resp_o latency is BEATS+2 cycles: accept, BEATS beats, DONE.
- Back-to-back: a new request asserted the cycle after resp_o is accepted in IDLE that cycle. This covers the controller's write-back followed immediately by a read.
- line_o holds the buffer contents at all times.
- Address_i and line_i changes after acceptance are ignored.
- resp_i in IDLE or DONE is ignored.
- Counter wrap: cnt returns to 0 after the last beat, via the IDLE clear.

Decomposition:
- Package burst_adaptor_pkg holds:
  - state enum: IDLE, READ, WRITE, DONE;
  - localparams BEATS, OFFS and the counter width, derived from the parameters.
- Single module; no sub-module needed. The line buffer with beat-indexed write/read is inline.

Test Plan:
- Read, consecutive resp_i: read_i=1, address_i=0x0000_1234; memory returns 0x1111..., 0x2222..., 0x3333..., 0x4444... on 4 back-to-back resp_i cycles.
  - Required: address_o=0x0000_1220 and read_o=1 throughout.
  - resp_o pulses 1 cycle after the 4th beat, with line_o={0x4444...,0x3333...,0x2222...,0x1111...}.
- Write, stalled: write_i=1, line_i={D3,D2,D1,D0}; resp_i pattern 1,0,0,1,1,0,1.
  - Required: burst_o=D0,D1,D1,D1,D2,D3,D3 across those cycles, write_o=1 until the last beat.
  - Then one resp_o pulse, then write_o=0.
- Write then read back-to-back: write burst completes; read_i is asserted the cycle after resp_o.
  - Required: read_o rises the following cycle with no lost request and no second resp_o.
- Simultaneous request: read_i=1 and write_i=1 in the same cycle.
  - Required: write_o=1 and read_o=0; a single write burst.
- Reset mid-read: rst=1 after 2 read beats.
  - Required: next cycle read_o=0, resp_o=0, line_o=0.
  - A subsequent read completes normally with 4 fresh beats.
- Idle noise: resp_i toggled while idle.
  - Required: no state change, resp_o stays 0.
